// File: rtl/timer_counter_ar.sv
// timer_counter_ar: gated timer/counter with configurable width.
// It counts either system clocks or synchronised falling edges of cin.
// Three overflow policies are supported: free-run, auto-reload and one-shot.
// Outputs are a sticky overflow flag (tf) and a one-cycle overflow pulse (ovf).
module timer_counter_ar #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gate,
  input  logic             intx,
  input  logic             tr,
  input  logic             cin,
  input  logic             c_t,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] reload,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tf,
  output logic             ovf
);

  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [SYNC_STAGES-1:0] cin_sync_q;
  logic [SYNC_STAGES-1:0] intx_sync_q;
  logic                   cin_d_q;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tf_q, tf_d;
  logic             ovf_q, ovf_d;
  logic             os_done_q, os_done_d;

  logic cin_s;
  logic intx_s;
  logic fe;
  logic run;
  logic inc;
  logic ovf_evt;

  // Synchroniser chains for the asynchronous pins, plus the edge-detect delay flop
  always_ff @(posedge clk) begin
    if (reset) begin
      cin_sync_q  <= '0;
      intx_sync_q <= '0;
      cin_d_q     <= 1'b0;
    end else begin
      cin_sync_q  <= {cin_sync_q[SYNC_STAGES-2:0], cin};
      intx_sync_q <= {intx_sync_q[SYNC_STAGES-2:0], intx};
      cin_d_q     <= cin_sync_q[SYNC_STAGES-1];
    end
  end

  // Run/increment/overflow qualification from the synchronised pins
  always_comb begin
    cin_s   = cin_sync_q[SYNC_STAGES-1];
    intx_s  = intx_sync_q[SYNC_STAGES-1];
    // Only a real 1->0 on the synchronised pin counts, so flipping c_t never fakes an edge
    fe      = cin_d_q & ~cin_s;
    run     = tr & ~os_done_q & (~gate | intx_s);
    inc     = run & (c_t ? fe : 1'b1);
    ovf_evt = inc & (count_q == {WIDTH{1'b1}});
  end

  // Next-state: load beats overflow beats plain increment; an overflow set beats tf_clr
  always_comb begin
    count_d   = count_q;
    tf_d      = tf_q;
    ovf_d     = 1'b0;
    os_done_d = os_done_q;
    if (tf_clr) tf_d = 1'b0;
    // A cycle with tr low re-arms the one-shot
    if (!tr) os_done_d = 1'b0;
    if (load) begin
      count_d   = load_val;
      os_done_d = 1'b0;
    end else if (ovf_evt) begin
      ovf_d = 1'b1;
      tf_d  = 1'b1;
      case (mode)
        MODE_RELOAD:  count_d = reload;
        MODE_ONESHOT: begin
          count_d   = '0;
          os_done_d = 1'b1;
        end
        default:      count_d = '0;
      endcase
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter, flags and one-shot state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      tf_q      <= 1'b0;
      ovf_q     <= 1'b0;
      os_done_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tf_q      <= tf_d;
      ovf_q     <= ovf_d;
      os_done_q <= os_done_d;
    end
  end

  assign count = count_q;
  assign tf    = tf_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_timer_counter_ar.sv
// Directed testbench for timer_counter_ar (WIDTH=16, SYNC_STAGES=2).
module tb_timer_counter_ar;

  logic        clk = 1'b0;
  logic        reset;
  logic        gate;
  logic        intx;
  logic        tr;
  logic        cin;
  logic        c_t;
  logic [1:0]  mode;
  logic [15:0] reload;
  logic        load;
  logic [15:0] load_val;
  logic        tf_clr;
  logic [15:0] count;
  logic        tf;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  timer_counter_ar #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .gate(gate), .intx(intx), .tr(tr), .cin(cin),
    .c_t(c_t), .mode(mode), .reload(reload), .load(load), .load_val(load_val),
    .tf_clr(tf_clr), .count(count), .tf(tf), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; gate = 1'b0; intx = 1'b0; tr = 1'b1; cin = 1'b0; c_t = 1'b0;
    mode = 2'b00; reload = 16'h0000; load = 1'b0; load_val = 16'h0000; tf_clr = 1'b0;

    // Reset held 3 cycles with tr high, then free counting
    step(3);
    check("rst_count", count, 16'd0);
    check("rst_tf", tf, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    reset = 1'b0;
    step(10);
    check("timer_10", count, 16'd10);

    // Gating: intx low blocks counting; raise intx and watch the sync latency
    do_reset();
    gate = 1'b1; intx = 1'b0; tr = 1'b1;
    step(20);
    check("gate_hold", count, 16'd0);
    intx = 1'b1;
    step(2);
    check("gate_sync_lat", count, 16'd0);
    step(1);
    check("gate_first_inc", count, 16'd1);
    step(1);
    check("gate_second_inc", count, 16'd2);
    gate = 1'b0;

    // Counter mode: 10 pulses 3 high / 3 low
    tr = 1'b0;
    do_reset();
    c_t = 1'b1; cin = 1'b0; tr = 1'b1;
    step(4);
    check("cnt_idle", count, 16'd0);
    for (int p = 0; p < 10; p++) begin
      cin = 1'b1; step(3);
      cin = 1'b0; step(3);
    end
    check("cnt_10_pulses", count, 16'd10);
    // Toggle c_t with cin held low: no spurious edge
    tr = 1'b0; c_t = 1'b0; step(3);
    c_t = 1'b1; tr = 1'b1; step(4);
    check("cnt_ct_toggle", count, 16'd10);
    c_t = 1'b0; step(1);
    c_t = 1'b1; step(4);
    check("cnt_ct_toggle2", count, 16'd11);
    c_t = 1'b0;

    // Auto-reload
    do_reset();
    mode = 2'b01; reload = 16'hFFF0; tr = 1'b1;
    load = 1'b1; load_val = 16'hFFFE;
    step(1);
    load = 1'b0;
    check("ar_load", count, 16'hFFFE);
    step(1);
    check("ar_ffff", count, 16'hFFFF);
    check("ar_no_ovf_yet", ovf, 1'b0);
    step(1);
    check("ar_reload", count, 16'hFFF0);
    check("ar_ovf", ovf, 1'b1);
    check("ar_tf", tf, 1'b1);
    step(1);
    check("ar_ovf_pulse", ovf, 1'b0);
    check("ar_tf_sticky", tf, 1'b1);
    check("ar_after", count, 16'hFFF1);
    tf_clr = 1'b1; step(1); tf_clr = 1'b0;
    check("ar_tf_clr", tf, 1'b0);
    load = 1'b1; load_val = 16'hFFFE; step(1); load = 1'b0;
    step(1);
    tf_clr = 1'b1; step(1); tf_clr = 1'b0;
    check("ar_set_beats_clr", tf, 1'b1);
    check("ar_ovf2", ovf, 1'b1);
    check("ar_reload2", count, 16'hFFF0);

    // One-shot
    do_reset();
    mode = 2'b10; tr = 1'b1;
    load = 1'b1; load_val = 16'hFFFF; step(1); load = 1'b0;
    check("os_load", count, 16'hFFFF);
    step(1);
    check("os_wrap", count, 16'd0);
    check("os_tf", tf, 1'b1);
    check("os_ovf", ovf, 1'b1);
    step(50);
    check("os_hold", count, 16'd0);
    check("os_ovf_low", ovf, 1'b0);
    tr = 1'b0; step(1);
    check("os_tr_low", count, 16'd0);
    tr = 1'b1; step(1);
    check("os_resume1", count, 16'd1);
    step(1);
    check("os_resume2", count, 16'd2);

    // Priority: load in an overflow cycle
    do_reset();
    mode = 2'b00; tr = 1'b1;
    load = 1'b1; load_val = 16'hFFFF; step(1);
    load_val = 16'h1234; step(1); load = 1'b0;
    check("pri_load_cnt", count, 16'h1234);
    check("pri_load_ovf", ovf, 1'b0);
    check("pri_load_tf", tf, 1'b0);
    step(5);
    check("pri_count_on", count, 16'h1239);
    // Mode 11 wraps to zero like free-run
    mode = 2'b11;
    load = 1'b1; load_val = 16'hFFFF; step(1); load = 1'b0;
    step(1);
    check("m11_wrap", count, 16'd0);
    check("m11_tf", tf, 1'b1);
    step(3);
    reset = 1'b1; step(1); reset = 1'b0;
    check("midrst_count", count, 16'd0);
    check("midrst_tf", tf, 1'b0);
    check("midrst_ovf", ovf, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
